spi_reg_frontend: RTL

// - SPI mode-0 target plus register bank; sits directly upstream of pwm_peripheral in the top level.
// - Synchronises the SCLK/COPI/nCS pins into clk and decodes 16-bit frames.
// - Frame layout: bit15 R/W (1 = write), bits14:8 address, bits7:0 data.
// - Holds the five control registers that pwm_peripheral consumes; reads are returned on CIPO.

---
 rtl/spi_reg_pkg.sv | 29 ++
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_reg_frontend.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register front end.
//   - Register addresses of the five pwm_peripheral control registers.
//   - Bit positions of the fields inside a 16-bit SPI frame.
//   - Frame-decoder FSM state encoding.
package spi_reg_pkg;

    localparam int unsigned ADDR_EN_OUT_LO = 0;
    localparam int unsigned ADDR_EN_OUT_HI = 1;
    localparam int unsigned ADDR_EN_PWM_LO = 2;
    localparam int unsigned ADDR_EN_PWM_HI = 3;
    localparam int unsigned ADDR_DUTY      = 4;

    localparam int unsigned FRAME_W  = 16;
    localparam int unsigned RW_BIT   = 15;
    localparam int unsigned ADDR_MSB = 14;
    localparam int unsigned ADDR_LSB = 8;

    // Bit counter must hold 0..16
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        ST_LOCKOUT,
        ST_IDLE,
        ST_SHIFT,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus a single-flop edge
// detector on the synchronised level.
//   clk      in  system clock
//   rst      in  synchronous active-high reset (all flops cleared to 0)
//   pin_i    in  asynchronous pin
//   level_o  out synchronised level
//   rise_o   out 1-cycle pulse on a synchronised 0->1 transition
//   fall_o   out 1-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Clearing to 0 (rather than the idle-high pin level) matters for ncs:
    // the synchronised chip select must be seen going high before the
    // front end will leave lockout after a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_frontend.sv
// SPI mode-0 target with the control register bank for pwm_peripheral.
// Frames are 16 bits, MSB first: bit15 R/W (1 = write), bits14:8 address,
// bits7:0 data. Writes commit when chip select rises; reads return the
// addressed register on cipo during bits 9..16.
//   clk, rst                     system clock, synchronous active-high reset
//   sclk, copi, ncs              asynchronous SPI pins
//   cipo, cipo_oe                SPI read data and its output enable
//   en_reg_out_7_0 .. pwm_duty_cycle_out   registers 0x00..0x04
//   wr_strobe                    1-cycle pulse on each committed write
//   frame_err                    1-cycle pulse when a frame is discarded
module spi_reg_frontend
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_REGS    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              cipo,
    output logic              cipo_oe,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle_out,
    output logic              wr_strobe,
    output logic              frame_err
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic copi_s, copi_rise, copi_fall;
    logic unused_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin_i(sclk),
        .level_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst(rst), .pin_i(ncs),
        .level_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst(rst), .pin_i(copi),
        .level_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
    );

    // Only edges of sclk and the level of copi drive decisions
    assign unused_edges = ^{sclk_s, copi_rise, copi_fall};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                rd_q, rd_d;
    logic                cipo_q, cipo_d;
    logic                oe_q, oe_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [FRAME_W-1:0]  shift_nx;
    logic [DATA_W-1:0]   rd_data;
    logic [ADDR_W-1:0]   wr_addr;
    logic                wr_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOCKOUT;
            cnt_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            rd_q    <= 1'b0;
            cipo_q  <= 1'b0;
            oe_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            rd_q    <= rd_d;
            cipo_q  <= cipo_d;
            oe_q    <= oe_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_strobe && wr_addr == ADDR_W'(i)) begin
                    regs_q[i] <= shift_q[DATA_W-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        out_d     = out_q;
        rd_d      = rd_q;
        cipo_d    = cipo_q;
        wr_strobe = 1'b0;
        frame_err = 1'b0;

        shift_nx = {shift_q[FRAME_W-2:0], copi_s};
        wr_addr  = shift_q[ADDR_MSB:ADDR_LSB];
        wr_hit   = shift_q[RW_BIT] && (wr_addr < ADDR_W'(NUM_REGS));

        // After the 8th bit the R/W flag and address sit in the low byte
        // of the freshly shifted value; unimplemented addresses read as 0.
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (shift_nx[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_data = regs_q[i];
            end
        end

        unique case (state_q)
            ST_LOCKOUT: begin
                if (ncs_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise) begin
                    state_d   = ST_IDLE;
                    frame_err = 1'b1;
                end else if (sclk_rise) begin
                    shift_d = shift_nx;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7) && !shift_nx[ADDR_W]) begin
                        out_d = rd_data;
                        rd_d  = 1'b1;
                    end
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (ncs_rise) begin
                    state_d   = ST_IDLE;
                    wr_strobe = wr_hit;
                end else if (sclk_rise) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (ncs_rise) begin
                    state_d   = ST_IDLE;
                    frame_err = 1'b1;
                end
            end
            default: state_d = ST_LOCKOUT;
        endcase

        // sclk rise and fall never coincide, so this cannot collide with
        // the out-shifter load above.
        if (rd_q && sclk_fall) begin
            cipo_d = out_q[DATA_W-1];
            out_d  = {out_q[DATA_W-2:0], 1'b0};
        end

        if (state_d == ST_IDLE || state_d == ST_LOCKOUT) begin
            rd_d   = 1'b0;
            cipo_d = 1'b0;
        end

        // Not driven while locked out: the host is not talking to us then
        oe_d = !ncs_s && (state_q != ST_LOCKOUT);

        if (rst) begin
            wr_strobe = 1'b0;
            frame_err = 1'b0;
        end
    end

    assign cipo               = cipo_q;
    assign cipo_oe            = oe_q;
    assign en_reg_out_7_0     = regs_q[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8    = regs_q[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0     = regs_q[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8    = regs_q[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle_out = regs_q[ADDR_DUTY];

endmodule
